// File: rtl/lcd_pattern_gen.sv
// Parametrised RGB LCD timing and test-pattern generator.
// Latency: one register stage; sync, DE, colour, coordinates and frame_start all describe the same pixel.
// Backpressure: none. The panel is free-running and every cycle emits one pixel slot.
//
// Ports: clk (pixel clock), rst_n (async active-low), mode (pattern select),
// solid_rgb (mode-3 background, {r,g,b}), lcd_hs/lcd_vs/lcd_de, lcd_r/g/b,
// active_x/active_y (pixel coordinates, 0 outside active), frame_start (pulse on pixel 0,0).
module lcd_pattern_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 29,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int R_W      = 5,
  parameter int G_W      = 6,
  parameter int B_W      = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode,
  input  logic [R_W+G_W+B_W-1:0] solid_rgb,
  output logic                   lcd_hs,
  output logic                   lcd_vs,
  output logic                   lcd_de,
  output logic [R_W-1:0]         lcd_r,
  output logic [G_W-1:0]         lcd_g,
  output logic [B_W-1:0]         lcd_b,
  output logic [11:0]            active_x,
  output logic [11:0]            active_y,
  output logic                   frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] BAR_W    = 12'(H_ACTIVE / 8);
  localparam logic [11:0] H_EDGE   = 12'(H_ACTIVE - 1);
  localparam logic [11:0] V_EDGE   = 12'(V_ACTIVE - 1);
  localparam logic        HS_ON    = 1'(HS_POL);
  localparam logic        VS_ON    = 1'(VS_POL);

  logic [11:0] h_cnt, v_cnt;
  logic [7:0]  frame_cnt;
  logic [11:0] bar_pos;
  logic [1:0]  mode_q;

  logic        h_wrap, v_wrap, frame_wrap, first_px;
  logic        de_c, hs_c, vs_c;
  logic [1:0]  mode_eff;
  logic [11:0] bar_idx;
  logic [12:0] bar_next;
  logic        in_bar;
  logic [R_W-1:0] pr;
  logic [G_W-1:0] pg;
  logic [B_W-1:0] pb;

  assign h_wrap     = (h_cnt == H_LAST);
  assign v_wrap     = (v_cnt == V_LAST);
  assign frame_wrap = h_wrap && v_wrap;
  assign first_px   = (h_cnt == 12'd0) && (v_cnt == 12'd0);

  assign de_c = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_c = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_c = (v_cnt >= VS_START) && (v_cnt < VS_END);

  // On pixel (0,0) the live mode input is used so that a new selection is
  // already visible on the very first pixel of the frame it is latched for.
  assign mode_eff = first_px ? mode : mode_q;

  assign bar_idx  = h_cnt / BAR_W;
  assign bar_next = {1'b0, bar_pos} + 13'd4;
  // 13-bit compare keeps bar_pos+16 from wrapping near the right edge.
  assign in_bar   = ({1'b0, h_cnt} >= {1'b0, bar_pos}) &&
                    ({1'b0, h_cnt} <  ({1'b0, bar_pos} + 13'd16));

  always_comb begin
    pr = '0;
    pg = '0;
    pb = '0;
    case (mode_eff)
      2'd0: begin
        if (bar_idx < 12'd8) begin
          // Bars in order W,Y,C,G,M,R,B,K encoded as {r,g,b} on/off bits.
          case (bar_idx[2:0])
            3'd0: begin pr = '1; pg = '1; pb = '1; end
            3'd1: begin pr = '1; pg = '1;          end
            3'd2: begin          pg = '1; pb = '1; end
            3'd3: begin          pg = '1;          end
            3'd4: begin pr = '1;          pb = '1; end
            3'd5: begin pr = '1;                   end
            3'd6: begin                   pb = '1; end
            default: ;
          endcase
        end
      end
      2'd1: begin
        if ((h_cnt[4:0] == 5'd0) || (v_cnt[4:0] == 5'd0) ||
            (h_cnt == H_EDGE) || (v_cnt == V_EDGE)) begin
          pr = '1; pg = '1; pb = '1;
        end
      end
      2'd2: begin
        pr = R_W'(h_cnt >> 5);
        pg = G_W'(v_cnt >> 3);
        pb = B_W'(frame_cnt);
      end
      default: begin
        if (in_bar) begin
          pr = '1; pg = '1; pb = '1;
        end else begin
          {pr, pg, pb} = solid_rgb;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_cnt   <= '0;
      bar_pos     <= '0;
      mode_q      <= '0;
      lcd_de      <= 1'b0;
      lcd_hs      <= ~HS_ON;
      lcd_vs      <= ~VS_ON;
      lcd_r       <= '0;
      lcd_g       <= '0;
      lcd_b       <= '0;
      active_x    <= '0;
      active_y    <= '0;
      frame_start <= 1'b0;
    end else begin
      h_cnt <= h_wrap ? 12'd0 : h_cnt + 12'd1;
      if (h_wrap) begin
        v_cnt <= v_wrap ? 12'd0 : v_cnt + 12'd1;
      end
      if (first_px) begin
        mode_q <= mode;
      end
      if (frame_wrap) begin
        frame_cnt <= frame_cnt + 8'd1;
        bar_pos   <= (bar_next < {1'b0, H_ACT}) ? bar_next[11:0] : 12'd0;
      end
      lcd_de      <= de_c;
      lcd_hs      <= hs_c ? HS_ON : ~HS_ON;
      lcd_vs      <= vs_c ? VS_ON : ~VS_ON;
      lcd_r       <= de_c ? pr : '0;
      lcd_g       <= de_c ? pg : '0;
      lcd_b       <= de_c ? pb : '0;
      active_x    <= de_c ? h_cnt : 12'd0;
      active_y    <= de_c ? v_cnt : 12'd0;
      frame_start <= first_px && de_c;
    end
  end

endmodule

// File: tb/tb_lcd_pattern_gen.sv
module tb_lcd_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode0 = 2'd0, mode1 = 2'd0;
  logic [15:0] solid0 = 16'h0000, solid1 = 16'h0000;

  logic        hs0, vs0, de0, fs0, hs1, vs1, de1, fs1;
  logic [4:0]  r0, b0, r1, b1;
  logic [5:0]  g0, g1;
  logic [11:0] ax0, ay0, ax1, ay1;
  logic [15:0] rgb0, rgb1;

  assign rgb0 = {r0, g0, b0};
  assign rgb1 = {r1, g1, b1};

  always #5 clk = ~clk;

  // Default 800x480 timing, active-low syncs.
  lcd_pattern_gen dut0 (
    .clk(clk), .rst_n(rst_n), .mode(mode0), .solid_rgb(solid0),
    .lcd_hs(hs0), .lcd_vs(vs0), .lcd_de(de0),
    .lcd_r(r0), .lcd_g(g0), .lcd_b(b0),
    .active_x(ax0), .active_y(ay0), .frame_start(fs0)
  );

  // Small 80x24 frame (96x30 total) with active-high syncs for frame-level behaviour.
  lcd_pattern_gen #(
    .H_ACTIVE(80), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .HS_POL(1), .VS_POL(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .mode(mode1), .solid_rgb(solid1),
    .lcd_hs(hs1), .lcd_vs(vs1), .lcd_de(de1),
    .lcd_r(r1), .lcd_g(g1), .lcd_b(b1),
    .active_x(ax1), .active_y(ay1), .frame_start(fs1)
  );

  int checks = 0;
  int errors = 0;
  int pix = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next pixel slot; outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
    pix++;
  endtask

  task automatic wait_to(input int target);
    while (pix < target) tick();
  endtask

  initial begin
    int e_de0 = 0, e_hs0 = 0, e_vs0 = 0, e_fs0 = 0;
    int e_de1 = 0, e_hs1 = 0, e_vs1 = 0, e_fs1 = 0, e_xy1 = 0, e_blank1 = 0;
    int vs1_high = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_hs0", hs0, 1'b1);
    chk("rst_vs0", vs0, 1'b1);
    chk("rst_de0", de0, 1'b0);
    chk("rst_rgb0", rgb0, 16'h0000);
    chk("rst_fs0", fs0, 1'b0);
    chk("rst_hs1_activehigh", hs1, 1'b0);
    chk("rst_vs1_activehigh", vs1, 1'b0);

    rst_n = 1'b1;
    pix = -1;

    // First 2881 pixel slots: per-cycle timing of both instances.
    for (int k = 0; k <= 2880; k++) begin
      int h0, h1, v1;
      logic x_de0, x_hs0, x_de1, x_hs1, x_vs1, x_fs1;
      tick();
      h0 = pix % 1056;
      h1 = pix % 96;
      v1 = (pix / 96) % 30;
      x_de0 = (h0 < 800);
      x_hs0 = (h0 >= 840 && h0 < 968) ? 1'b0 : 1'b1;
      x_de1 = (h1 < 80) && (v1 < 24);
      x_hs1 = (h1 >= 84 && h1 < 92);
      x_vs1 = (v1 >= 26 && v1 < 28);
      x_fs1 = (h1 == 0) && (v1 == 0);
      if (de0 !== x_de0) e_de0++;
      if (hs0 !== x_hs0) e_hs0++;
      if (vs0 !== 1'b1) e_vs0++;
      if (fs0 !== (pix == 0)) e_fs0++;
      if (de1 !== x_de1) e_de1++;
      if (hs1 !== x_hs1) e_hs1++;
      if (vs1 !== x_vs1) e_vs1++;
      if (fs1 !== x_fs1) e_fs1++;
      if (vs1 === 1'b1 && pix < 2880) vs1_high++;
      if (ax1 !== (x_de1 ? 12'(h1) : 12'd0) || ay1 !== (x_de1 ? 12'(v1) : 12'd0)) e_xy1++;
      if (!x_de1 && rgb1 !== 16'h0000) e_blank1++;

      if (pix == 0) begin
        chk("first_de0", de0, 1'b1);
        chk("first_fs0", fs0, 1'b1);
        chk("first_ax0", ax0, 12'd0);
        chk("m0_x0_white", rgb0, 16'hFFFF);
        chk("first_fs1", fs1, 1'b1);
      end
      if (pix == 100) begin
        chk("m0_x100_yellow", rgb0, 16'hFFE0);
        chk("ax0_100", ax0, 12'd100);
      end
      if (pix == 799) chk("m0_x799_black", rgb0, 16'h0000);
      if (pix == 1061) begin
        chk("line1_ay0", ay0, 12'd1);
        chk("line1_ax0", ax0, 12'd5);
      end
      if (pix == 960) mode1 = 2'd2;
      if (pix == 1152) chk("midframe_keeps_bars_white", rgb1, 16'hFFFF);
      if (pix == 1167) chk("midframe_keeps_bars_yellow", rgb1, 16'hFFE0);
    end
    chk("de0_timing", e_de0, 0);
    chk("hs0_timing", e_hs0, 0);
    chk("vs0_idle", e_vs0, 0);
    chk("fs0_timing", e_fs0, 0);
    chk("de1_timing", e_de1, 0);
    chk("hs1_timing", e_hs1, 0);
    chk("vs1_timing", e_vs1, 0);
    chk("fs1_spacing", e_fs1, 0);
    chk("vs1_high_cycles", vs1_high, 192);
    chk("xy1_coords", e_xy1, 0);
    chk("rgb1_blanking", e_blank1, 0);

    // Gradient in frames 1 and 2 at pixel (64,16)
    wait_to(2880 + 16*96 + 64);
    chk("grad_f1", rgb1, 16'h1041);
    wait_to(2*2880 + 16*96 + 64);
    chk("grad_f2", rgb1, 16'h1042);
    mode1 = 2'd1;

    // Grid in frame 3
    wait_to(3*2880 + 5*96 + 32);
    chk("grid_x32", rgb1, 16'hFFFF);
    tick();
    chk("grid_x33", rgb1, 16'h0000);
    wait_to(3*2880 + 5*96 + 79);
    chk("grid_right_edge", rgb1, 16'hFFFF);
    wait_to(3*2880 + 5*96 + 85);
    chk("grid_porch_rgb", rgb1, 16'h0000);
    chk("grid_porch_de", de1, 1'b0);
    chk("grid_porch_ax", ax1, 12'd0);
    wait_to(3*2880 + 23*96 + 33);
    chk("grid_bottom_edge", rgb1, 16'hFFFF);
    mode1 = 2'd3;
    solid1 = 16'h001F;

    // Moving bar: frame f has bar_pos = 4f mod 80
    wait_to(4*2880 + 15);
    chk("bar_f4_x15", rgb1, 16'h001F);
    tick();
    chk("bar_f4_x16", rgb1, 16'hFFFF);
    wait_to(4*2880 + 31);
    chk("bar_f4_x31", rgb1, 16'hFFFF);
    tick();
    chk("bar_f4_x32", rgb1, 16'h001F);
    wait_to(4*2880 + 85);
    chk("bar_porch_rgb", rgb1, 16'h0000);
    wait_to(19*2880 + 96 + 75);
    chk("bar_f19_x75", rgb1, 16'h001F);
    tick();
    chk("bar_f19_x76", rgb1, 16'hFFFF);
    wait_to(19*2880 + 96 + 79);
    chk("bar_f19_x79", rgb1, 16'hFFFF);
    wait_to(20*2880);
    chk("bar_wrap_x0", rgb1, 16'hFFFF);
    wait_to(20*2880 + 15);
    chk("bar_wrap_x15", rgb1, 16'hFFFF);
    tick();
    chk("bar_wrap_x16", rgb1, 16'h001F);
    wait_to(21*2880 + 3);
    chk("bar_f21_x3", rgb1, 16'h001F);
    tick();
    chk("bar_f21_x4", rgb1, 16'hFFFF);

    // Asynchronous reset mid-line, checked before any clock edge
    wait_to(60500);
    chk("pre_reset_de0", de0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_de0", de0, 1'b0);
    chk("async_rst_rgb0", rgb0, 16'h0000);
    chk("async_rst_ax0", ax0, 12'd0);
    chk("async_rst_hs0", hs0, 1'b1);
    chk("async_rst_hs1", hs1, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pix = -1;
    tick();
    chk("restart_de0", de0, 1'b1);
    chk("restart_fs0", fs0, 1'b1);
    chk("restart_ax0", ax0, 12'd0);
    chk("restart_fs1", fs1, 1'b1);
    tick();
    chk("restart_ax0_1", ax0, 12'd1);
    chk("restart_fs0_pulse", fs0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
